// File: rtl/slc3_mem_arbiter.sv
// Arbitrates the SLC-3 program memory between the CPU port and the loader, and
// intercepts the memory-mapped I/O word (reads return SW, writes load hex_out).
module slc3_mem_arbiter #(
    parameter int              ADDR_W       = 16,
    parameter int              DATA_W       = 16,
    parameter int              MEM_LATENCY  = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR    = 16'hFFFF,
    parameter int              MAX_LD_BURST = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ready,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [9:0]        SW,
    output logic [15:0]       hex_out,
    output logic [1:0]        owner
);

    localparam int STREAK_W = $clog2(MAX_LD_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE,
        S_IO
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LD   = 2'b10
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          wait_cnt_q, wait_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                ld_ready_q, ld_ready_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
    logic [15:0]         hex_q, hex_d;

    logic                grant_cpu, grant_ld;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   resp_data;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        streak_d    = streak_q;
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ready_d = 1'b0;
        ld_ready_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        hex_d       = hex_q;
        grant_cpu   = 1'b0;
        grant_ld    = 1'b0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        resp_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (!cpu_req) begin
                    streak_d = '0;
                end
                // An I/O completion pulses ready while already back in IDLE; a requester
                // still holding req in that cycle must not be granted twice.
                if (!(cpu_ready_q || ld_ready_q)) begin
                    grant_cpu = cpu_req && (!ld_req || streak_q == STREAK_W'(MAX_LD_BURST));
                    grant_ld  = ld_req && !grant_cpu;
                end
                if (grant_cpu || grant_ld) begin
                    sel_we    = grant_cpu ? cpu_we    : ld_we;
                    sel_addr  = grant_cpu ? cpu_addr  : ld_addr;
                    sel_wdata = grant_cpu ? cpu_wdata : ld_wdata;
                    we_d      = sel_we;
                    wdata_d   = sel_wdata;
                    owner_d   = grant_cpu ? OWN_CPU : OWN_LD;
                    if (grant_cpu) begin
                        streak_d = '0;
                    end else if (cpu_req && streak_q != STREAK_W'(MAX_LD_BURST)) begin
                        streak_d = streak_q + 1'b1;
                    end
                    if (sel_addr == IO_ADDR) begin
                        state_d = S_IO;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_ce_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                    end
                end
            end

            S_ACCESS: begin
                state_d    = S_WAIT;
                wait_cnt_d = 3'd1;
            end

            S_WAIT: begin
                if (wait_cnt_q == 3'(MEM_LATENCY)) begin
                    state_d   = S_DONE;
                    resp_data = we_q ? '0 : mem_rdata;
                    if (owner_q == OWN_CPU) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = resp_data;
                    end else begin
                        ld_ready_d = 1'b1;
                        ld_rdata_d = resp_data;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end

            S_DONE: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end

            S_IO: begin
                resp_data = we_q ? '0 : DATA_W'(SW);
                if (we_q) begin
                    hex_d = 16'(wdata_q);
                end
                if (owner_q == OWN_CPU) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = resp_data;
                end else begin
                    ld_ready_d = 1'b1;
                    ld_rdata_d = resp_data;
                end
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            streak_q    <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            hex_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            streak_q    <= streak_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ready_q <= cpu_ready_d;
            ld_ready_q  <= ld_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            hex_q       <= hex_d;
        end
    end

    assign ld_rdata  = ld_rdata_q;
    assign ld_ready  = ld_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hex_out   = hex_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Scoreboard bench for slc3_mem_arbiter: drivers queue expected responses, a
// negedge monitor pops and compares them whenever a ready pulse appears.
module tb_slc3_mem_arbiter;

    localparam int L = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ld_req, ld_we, cpu_req, cpu_we;
    logic [15:0] ld_addr, ld_wdata, cpu_addr, cpu_wdata;
    logic [15:0] ld_rdata, cpu_rdata;
    logic        ld_ready, cpu_ready;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [9:0]  SW;
    logic [15:0] hex_out;
    logic [1:0]  owner;

    slc3_mem_arbiter #(.MEM_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ready(ld_ready),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .SW(SW), .hex_out(hex_out), .owner(owner)
    );

    always #5 Clk = ~Clk;

    int cycle = 0;
    int ce_count = 0;
    always @(posedge Clk) begin
        cycle <= cycle + 1;
        if (mem_ce) ce_count <= ce_count + 1;
    end

    // Memory model: read data appears L cycles after the mem_ce cycle.
    logic [15:0] mem [0:65535];
    logic [15:0] pipe [0:L-1];
    bit          preloaded = 1'b0;
    always @(posedge Clk) begin
        if (!preloaded) begin
            mem[16'h0042] <= 16'h1234;
            preloaded     <= 1'b1;
        end else if (mem_ce && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= (mem_ce && !mem_we) ? mem[mem_addr] : 16'hDEAD;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          issue;
    } exp_t;

    exp_t       cpu_q[$];
    exp_t       ld_q[$];
    logic [1:0] grant_log[$];
    logic [1:0] prev_owner = 2'b00;
    exp_t       mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (cpu_ready || ld_ready) check("ready_onehot", 32'(cpu_ready & ld_ready), 0);
            if (cpu_ready) begin
                check("cpu_expected", 32'(cpu_q.size() != 0), 1);
                if (cpu_q.size() != 0) begin
                    mon_e = cpu_q.pop_front();
                    check("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
                    if (mon_e.lat >= 0) check("cpu_latency", cycle - mon_e.issue, mon_e.lat);
                end
            end
            if (ld_ready) begin
                check("ld_expected", 32'(ld_q.size() != 0), 1);
                if (ld_q.size() != 0) begin
                    mon_e = ld_q.pop_front();
                    check("ld_rdata", 32'(ld_rdata), 32'(mon_e.data));
                    if (mon_e.lat >= 0) check("ld_latency", cycle - mon_e.issue, mon_e.lat);
                end
            end
            if (owner != 2'b00 && prev_owner == 2'b00) grant_log.push_back(owner);
        end
        prev_owner <= owner;
    end

    task automatic cpu_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp, input int lat, input int drop_after,
                            input bit hold);
        bit got = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_q.push_back('{exp, lat, cycle});
        for (int n = 1; n <= 200; n++) begin
            @(negedge Clk);
            if (cpu_ready) begin
                got = 1;
                break;
            end
            if (n == drop_after) cpu_req = 1'b0;
        end
        check("cpu_done_in_time", 32'(got), 1);
        if (!hold) begin
            cpu_req = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic ld_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp, input int lat, input bit hold);
        bit got = 0;
        ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        ld_q.push_back('{exp, lat, cycle});
        for (int n = 1; n <= 200; n++) begin
            @(negedge Clk);
            if (ld_ready) begin
                got = 1;
                break;
            end
        end
        check("ld_done_in_time", 32'(got), 1);
        if (!hold) begin
            ld_req = 1'b0;
            @(negedge Clk);
        end
    endtask

    function automatic logic any_out();
        return |{ld_rdata, ld_ready, cpu_rdata, cpu_ready, mem_ce, mem_we,
                 mem_addr, mem_wdata, hex_out, owner};
    endfunction

    initial begin
        int ce_before;
        bit saw_ce;
        Reset = 1'b1;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        SW = 10'h145;
        repeat (3) @(negedge Clk);
        check("reset_outputs_zero", 32'(any_out()), 0);
        check("reset_owner", 32'(owner), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // I/O read and write: no memory strobe, ready two cycles after issue
        ce_before = ce_count;
        cpu_xact(1'b0, 16'hFFFF, 16'h0000, 16'h0145, 2, -1, 1'b0);
        cpu_xact(1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 2, -1, 1'b0);
        check("io_hex_out", 32'(hex_out), 32'h0000BEEF);
        check("io_no_mem_ce", ce_count - ce_before, 0);
        check("io_owner_idle", 32'(owner), 0);

        // Reset in the middle of a memory access abandons it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 16'h0;
        saw_ce = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge Clk);
            if (mem_ce) begin
                saw_ce = 1;
                break;
            end
        end
        check("mid_reset_reached_access", 32'(saw_ce), 1);
        Reset = 1'b1;
        #1;
        check("mid_reset_outputs_zero", 32'(any_out()), 0);
        check("mid_reset_hex_cleared", 32'(hex_out), 0);
        cpu_req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // CPU read after reset: mem_ce one cycle after issue, ready at issue+4
        ce_before = ce_count;
        cpu_xact(1'b0, 16'h0042, 16'h0000, 16'h1234, L + 2, -1, 1'b0);
        check("cpu_read_one_strobe", ce_count - ce_before, 1);

        // Tie: 8 loader grants, then 1 CPU grant, repeated
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 16; i++)
                    ld_xact(1'b1, 16'h3000 + 16'(i), 16'hA000 + 16'(i), 16'h0000, -1, i < 15);
            end
            begin
                for (int k = 0; k < 2; k++)
                    cpu_xact(1'b0, 16'h0042, 16'h0000, 16'h1234, -1, -1, k < 1);
            end
        join
        check("tie_grant_count", grant_log.size(), 18);
        for (int i = 0; i < grant_log.size() && i < 18; i++)
            check($sformatf("tie_grant_%0d", i), 32'(grant_log[i]),
                  (i == 8 || i == 17) ? 32'h1 : 32'h2);

        // Loader write then CPU read of the same word
        ld_xact(1'b1, 16'h3000, 16'h5020, 16'h0000, L + 2, 1'b0);
        cpu_xact(1'b0, 16'h3000, 16'h0000, 16'h5020, L + 2, -1, 1'b0);
        ld_xact(1'b0, 16'h3001, 16'h0000, 16'hA001, L + 2, 1'b0);

        // CPU drops req two cycles into a read: ready still arrives on time
        cpu_xact(1'b0, 16'h0042, 16'h0000, 16'h1234, L + 2, 2, 1'b0);
        check("drop_owner_idle", 32'(owner), 0);
        cpu_xact(1'b0, 16'h3000, 16'h0000, 16'h5020, L + 2, -1, 1'b0);

        repeat (4) @(negedge Clk);
        check("cpu_queue_drained", cpu_q.size(), 0);
        check("ld_queue_drained", ld_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
